branch_pred_gshare: RTL and testbench

//  Parametrised successor to the 64-entry branch predictor: tagged direct-mapped BTB plus

---
 rtl/bpu_pkg.sv | 19 +
 rtl/bpu_pht.sv | 34 +++
 rtl/branch_pred_gshare.sv | 106 ++++++++++
 tb/tb_branch_pred_gshare.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared helpers for the gshare branch predictor: counter reset value and
// saturating counter update, computed at full int width and narrowed by callers.
package bpu_pkg;

    function automatic logic [31:0] ctr_init(input int unsigned ctr_bits);
        if (ctr_bits <= 1) return '0;
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int unsigned ctr_bits);
        logic [31:0] ctr_max;
        ctr_max = (ctr_bits >= 32) ? '1 : ((32'd1 << ctr_bits) - 32'd1);
        if (taken) return (ctr == ctr_max) ? ctr : ctr + 32'd1;
        return (ctr == '0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: saturating counters with one combinational read port
// and one clocked read-modify-write training port.
module bpu_pht
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                ctr_q[i] <= CTR_BITS'(ctr_init(CTR_BITS));
        end else if (wr_en) begin
            ctr_q[wr_idx] <= CTR_BITS'(sat_update(32'(ctr_q[wr_idx]), wr_taken, CTR_BITS));
        end
    end

    // Read sees the pre-write value on a same-entry collision.
    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_pred_gshare.sv
// Gshare branch predictor: tagged direct-mapped BTB plus PHT indexed by
// PC XOR speculative global history, with history repair on mispredict.
module branch_pred_gshare
    import bpu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned IDX_BITS      = 6,
    parameter int unsigned TAG_BITS      = 8,
    parameter int unsigned HIST_BITS     = 4,
    parameter int unsigned CTR_BITS      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pcF,
    input  logic                     stallF,
    output logic                     predict_takenF,
    output logic [ADDRESS_WIDTH-1:0] predict_targetF,
    output logic [HIST_BITS-1:0]     ghr_snapF,
    input  logic [ADDRESS_WIDTH-1:0] pcE,
    input  logic                     branch_validE,
    input  logic                     branch_takenE,
    input  logic [ADDRESS_WIDTH-1:0] targetE,
    input  logic                     predict_takenE,
    input  logic [ADDRESS_WIDTH-1:0] predict_targetE,
    input  logic [HIST_BITS-1:0]     ghr_snapE,
    output logic                     mispredictE
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_LO  = IDX_BITS + 2;
    localparam int unsigned TAG_HI  = IDX_BITS + TAG_BITS + 1;

    typedef struct packed {
        logic                     valid;
        logic [TAG_BITS-1:0]      tag;
        logic [ADDRESS_WIDTH-1:0] target;
    } btb_entry_t;

    btb_entry_t          btb_q [ENTRIES];
    btb_entry_t          btb_f;
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] ghr_repair;
    logic [HIST_BITS-1:0] ghr_spec;
    logic [IDX_BITS-1:0]  idx_f;
    logic [IDX_BITS-1:0]  idx_e;
    logic [TAG_BITS-1:0]  tag_f;
    logic [TAG_BITS-1:0]  tag_e;
    logic [CTR_BITS-1:0]  pht_ctr_f;
    logic                 hit_f;
    logic                 unused_pc_bits;

    assign idx_f = pcF[IDX_BITS+1:2];
    assign idx_e = pcE[IDX_BITS+1:2];
    assign tag_f = pcF[TAG_HI:TAG_LO];
    assign tag_e = pcE[TAG_HI:TAG_LO];
    assign unused_pc_bits = ^{pcF[1:0], pcF[ADDRESS_WIDTH-1:TAG_HI+1],
                              pcE[1:0], pcE[ADDRESS_WIDTH-1:TAG_HI+1]};

    bpu_pht #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_f ^ IDX_BITS'(ghr_q)),
        .rd_ctr   (pht_ctr_f),
        .wr_en    (branch_validE),
        .wr_idx   (idx_e ^ IDX_BITS'(ghr_snapE)),
        .wr_taken (branch_takenE)
    );

    assign btb_f           = btb_q[idx_f];
    assign hit_f           = btb_f.valid && (btb_f.tag == tag_f);
    assign predict_takenF  = hit_f && pht_ctr_f[CTR_BITS-1];
    assign predict_targetF = hit_f ? btb_f.target : '0;
    assign ghr_snapF       = ghr_q;

    assign mispredictE = branch_validE &&
                         ((branch_takenE != predict_takenE) ||
                          (branch_takenE && (predict_targetE != targetE)));

    // A 1-bit history has no older bits to keep; the slice would be empty.
    if (HIST_BITS == 1) begin : g_hist1
        assign ghr_repair = branch_takenE;
        assign ghr_spec   = predict_takenF;
    end else begin : g_histn
        assign ghr_repair = {ghr_snapE[HIST_BITS-2:0], branch_takenE};
        assign ghr_spec   = {ghr_q[HIST_BITS-2:0], predict_takenF};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   ghr_q <= '0;
        else if (mispredictE)      ghr_q <= ghr_repair;
        else if (!stallF && hit_f) ghr_q <= ghr_spec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                btb_q[i] <= '0;
        end else if (branch_validE && branch_takenE) begin
            btb_q[idx_e] <= '{valid: 1'b1, tag: tag_e, target: targetE};
        end
    end

endmodule

// File: tb/tb_branch_pred_gshare.sv
// Directed bench for branch_pred_gshare at default parameters (6-bit index,
// 8-bit tag, 4-bit history, 2-bit counters).
module tb_branch_pred_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        stallF;
    logic        predict_takenF;
    logic [31:0] predict_targetF;
    logic [3:0]  ghr_snapF;
    logic [31:0] pcE;
    logic        branch_validE;
    logic        branch_takenE;
    logic [31:0] targetE;
    logic        predict_takenE;
    logic [31:0] predict_targetE;
    logic [3:0]  ghr_snapE;
    logic        mispredictE;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_pred_gshare #(
        .ADDRESS_WIDTH (32),
        .IDX_BITS      (6),
        .TAG_BITS      (8),
        .HIST_BITS     (4),
        .CTR_BITS      (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pcF             (pcF),
        .stallF          (stallF),
        .predict_takenF  (predict_takenF),
        .predict_targetF (predict_targetF),
        .ghr_snapF       (ghr_snapF),
        .pcE             (pcE),
        .branch_validE   (branch_validE),
        .branch_takenE   (branch_takenE),
        .targetE         (targetE),
        .predict_takenE  (predict_takenE),
        .predict_targetE (predict_targetE),
        .ghr_snapE       (ghr_snapE),
        .mispredictE     (mispredictE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked 1ns later.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic p_taken, input logic [31:0] p_tgt, input logic [3:0] snap);
        branch_validE   = 1'b1;
        pcE             = pc;
        branch_takenE   = taken;
        targetE         = tgt;
        predict_takenE  = p_taken;
        predict_targetE = p_tgt;
        ghr_snapE       = snap;
    endtask

    task automatic idle_e();
        branch_validE   = 1'b0;
        pcE             = '0;
        branch_takenE   = 1'b0;
        targetE         = '0;
        predict_takenE  = 1'b0;
        predict_targetE = '0;
        ghr_snapE       = '0;
    endtask

    initial begin
        rst    = 1'b0;
        pcF    = 32'h40;
        stallF = 1'b1;
        idle_e();
        #1 rst = 1'b1;
        #1;
        check("rst_taken", 32'(predict_takenF), 32'd0);
        check("rst_target", predict_targetF, 32'h0);
        check("rst_ghr", 32'(ghr_snapF), 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check("post_rst_taken", 32'(predict_takenF), 32'd0);
        check("post_rst_target", predict_targetF, 32'h0);

        // Train 0x40 taken to 0x80 twice; counter 1 -> 3, history stays 0.
        train(32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 4'h0);
        #1 check("train_no_mispredict", 32'(mispredictE), 32'd0);
        next_cycle();
        next_cycle();
        idle_e();
        #1;
        check("hit_taken", 32'(predict_takenF), 32'd1);
        check("hit_target", predict_targetF, 32'h80);
        check("hit_ghr", 32'(ghr_snapF), 32'd0);

        // Three more taken (five total): counter pinned at 3.
        train(32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 4'h0);
        repeat (3) next_cycle();
        // One not-taken: 3 -> 2, still taken (a wrapping counter would read 1).
        train(32'h40, 1'b0, 32'h44, 1'b1, 32'h80, 4'h0);
        #1 check("nt_mispredict", 32'(mispredictE), 32'd1);
        next_cycle();
        idle_e();
        #1 check("ctr2_taken", 32'(predict_takenF), 32'd1);
        // Two more not-taken: 2 -> 0.
        train(32'h40, 1'b0, 32'h44, 1'b0, 32'h0, 4'h0);
        next_cycle();
        next_cycle();
        idle_e();
        #1;
        check("ctr0_taken", 32'(predict_takenF), 32'd0);
        check("nt_keeps_btb", predict_targetF, 32'h80);
        // Not-taken at 0 saturates; one taken then gives 1, still not taken.
        train(32'h40, 1'b0, 32'h44, 1'b0, 32'h0, 4'h0);
        next_cycle();
        train(32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 4'h0);
        next_cycle();
        idle_e();
        #1 check("ctr1_taken", 32'(predict_takenF), 32'd0);
        train(32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 4'h0);
        next_cycle();
        idle_e();
        #1 check("ctr2b_taken", 32'(predict_takenF), 32'd1);

        // Target mispredict: predicted 0x80, resolved 0x84. History repairs to 0001.
        train(32'h40, 1'b1, 32'h84, 1'b1, 32'h80, 4'h0);
        #1 check("tgt_mispredict", 32'(mispredictE), 32'd1);
        next_cycle();
        idle_e();
        #1;
        check("new_target", predict_targetF, 32'h84);
        check("repair_ghr", 32'(ghr_snapF), 32'h1);
        check("xor_idx_taken", 32'(predict_takenF), 32'd0);

        // Repair and a speculative fetch hit in the same cycle: repair wins.
        stallF = 1'b0;
        train(32'h40, 1'b1, 32'h84, 1'b0, 32'h84, 4'b0101);
        #1 check("dir_mispredict", 32'(mispredictE), 32'd1);
        next_cycle();
        idle_e();
        #1 check("repair_wins", 32'(ghr_snapF), 32'hB);
        // Speculative shift of a not-taken prediction (PHT[16^11] still weak).
        check("spec_pred", 32'(predict_takenF), 32'd0);
        next_cycle();
        #1 check("spec_shift", 32'(ghr_snapF), 32'h6);
        // BTB miss while unstalled holds history.
        pcF = 32'h44;
        next_cycle();
        #1 check("miss_hold", 32'(ghr_snapF), 32'h6);
        stallF = 1'b1;

        // Same index, different tag: miss.
        pcF = 32'h40 + (32'd4 << 6);
        #1;
        check("alias_taken", 32'(predict_takenF), 32'd0);
        check("alias_target", predict_targetF, 32'h0);

        // Async reset mid-training; the pending 0x48 update must be lost.
        @(negedge clk);
        pcF = 32'h40;
        train(32'h48, 1'b1, 32'h99, 1'b1, 32'h99, 4'h0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_target", predict_targetF, 32'h0);
        check("async_rst_ghr", 32'(ghr_snapF), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_e();
        #1 check("rst_clears_btb", predict_targetF, 32'h0);
        pcF = 32'h48;
        #1;
        check("rst_drops_write", predict_targetF, 32'h0);
        check("rst_drops_taken", 32'(predict_takenF), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
